// File: rtl/ss_stack_16b.sv
// ss_stack_16b: 16-bit hardware operand stack sitting just below the top register.
//
// Purpose:
//   Pushes the current top-register value (tr) and presents the next-of-stack word
//   (sr) to the ALU / mux sources. It also reports full/empty status and sticky
//   overflow/underflow error flags to the control unit.
//   Storage is a DEPTH-entry register file. A count register indexes it.
//
// Ports:
//   CLK        in   1        system clock, rising-edge active
//   reset      in   1        asynchronous active-high reset (count and flags only)
//   tr         in   16       push data
//   push       in   1        push request
//   pop        in   1        pop request (push+pop together = replace top)
//   clear      in   1        synchronous flush of count and error flags; highest priority
//   sr         out  16       mem[count-1] when non-empty, else 0
//   count      out  PTR_W+1  number of valid entries, 0..DEPTH
//   empty      out  1        count == 0
//   full       out  1        count == DEPTH
//   overflow   out  1        sticky: push-only request while full
//   underflow  out  1        sticky: pop request while empty

module ss_stack_16b #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned PTR_W = 3
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [15:0]      tr,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  output logic [15:0]      sr,
  output logic [PTR_W:0]   count,
  output logic             empty,
  output logic             full,
  output logic             overflow,
  output logic             underflow
);

  // The index arithmetic relies on DEPTH == 2**PTR_W.
  if (DEPTH < 2 || (1 << PTR_W) != DEPTH) begin : g_param_check
    $error("ss_stack_16b: DEPTH must be a power of two >= 2 and equal 2**PTR_W");
  end

  localparam logic [PTR_W:0]   CntDepth = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0]   CntOne   = (PTR_W+1)'(1);
  localparam logic [PTR_W-1:0] IdxOne   = PTR_W'(1);

  // State
  logic [15:0]      r_mem [DEPTH];
  logic [PTR_W:0]   r_count;
  logic             r_overflow;
  logic             r_underflow;

  // Combinational decode / next state
  logic             w_empty;
  logic             w_full;
  logic [PTR_W-1:0] w_push_idx;
  logic [PTR_W-1:0] w_top_idx;
  logic [PTR_W:0]   w_count_d;
  logic             w_overflow_d;
  logic             w_underflow_d;
  logic             w_we;
  logic [PTR_W-1:0] w_waddr;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == CntDepth);
  assign w_push_idx = r_count[PTR_W-1:0];
  // count-1 taken on the low bits. When count == DEPTH the low bits are 0, so the
  // result wraps to DEPTH-1 as intended. When count == 0 the value is unused
  // because sr is masked and no replace write happens on an empty stack.
  assign w_top_idx  = r_count[PTR_W-1:0] - IdxOne;

  always_comb begin
    w_count_d     = r_count;
    w_overflow_d  = r_overflow;
    w_underflow_d = r_underflow;
    w_we          = 1'b0;
    w_waddr       = w_push_idx;

    if (clear) begin
      w_count_d     = '0;
      w_overflow_d  = 1'b0;
      w_underflow_d = 1'b0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (w_full) begin
            w_overflow_d = 1'b1;
          end else begin
            w_we      = 1'b1;
            w_waddr   = w_push_idx;
            w_count_d = r_count + CntOne;
          end
        end
        2'b01: begin
          if (w_empty) begin
            w_underflow_d = 1'b1;
          end else begin
            w_count_d = r_count - CntOne;
          end
        end
        2'b11: begin
          if (w_empty) begin
            // The pop is rejected, but the push still lands in slot 0.
            w_underflow_d = 1'b1;
            w_we          = 1'b1;
            w_waddr       = w_push_idx;
            w_count_d     = CntOne;
          end else begin
            // Replace the top in place. This is legal even when full.
            w_we    = 1'b1;
            w_waddr = w_top_idx;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_count     <= w_count_d;
      r_overflow  <= w_overflow_d;
      r_underflow <= w_underflow_d;
    end
  end

  // The array has no reset; entries beyond count are never observed.
  always_ff @(posedge CLK) begin
    if (w_we) begin
      r_mem[w_waddr] <= tr;
    end
  end

  assign sr        = w_empty ? 16'h0000 : r_mem[w_top_idx];
  assign count     = r_count;
  assign empty     = w_empty;
  assign full      = w_full;
  assign overflow  = r_overflow;
  assign underflow = r_underflow;

endmodule

// File: tb/tb_ss_stack_16b.sv
// Directed self-checking bench for ss_stack_16b (DEPTH=8).
module tb_ss_stack_16b;

  logic        CLK;
  logic        reset;
  logic [15:0] tr;
  logic        push;
  logic        pop;
  logic        clear;
  logic [15:0] sr;
  logic [3:0]  count;
  logic        empty;
  logic        full;
  logic        overflow;
  logic        underflow;

  int n_pass  = 0;
  int n_total = 0;

  ss_stack_16b #(
    .DEPTH (8),
    .PTR_W (3)
  ) dut (
    .CLK       (CLK),
    .reset     (reset),
    .tr        (tr),
    .push      (push),
    .pop       (pop),
    .clear     (clear),
    .sr        (sr),
    .count     (count),
    .empty     (empty),
    .full      (full),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Apply one request across a rising edge, then sample 1 ns later.
  task automatic op(input logic p, input logic q, input logic c, input logic [15:0] t);
    push = p; pop = q; clear = c; tr = t;
    @(posedge CLK); #1;
    push = 1'b0; pop = 1'b0; clear = 1'b0; tr = 16'h0000;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; clear = 1'b0; tr = 16'h0000;
    #12;
    check("rst_count", count, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_sr", sr, 16'h0000);
    check("rst_ovf", overflow, 0);
    check("rst_udf", underflow, 0);
    #6 reset = 1'b0;
    @(posedge CLK); #1;

    // Basic push / pop
    op(1, 0, 0, 16'h1111);
    op(1, 0, 0, 16'h2222);
    op(1, 0, 0, 16'h3333);
    check("p3_count", count, 3);
    check("p3_sr", sr, 16'h3333);
    op(0, 1, 0, 16'h0000);
    check("pop_count", count, 2);
    check("pop_sr", sr, 16'h2222);
    op(0, 0, 1, 16'h0000);
    check("clr_count", count, 0);

    // Fill, overflow, drain in LIFO order
    for (int i = 0; i < 8; i++) op(1, 0, 0, 16'hA000 + 16'(i));
    check("fill_full", full, 1);
    check("fill_count", count, 8);
    check("fill_sr", sr, 16'hA007);
    op(1, 0, 0, 16'hBEEF);
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, 8);
    check("ovf_sr", sr, 16'hA007);
    for (int k = 1; k <= 8; k++) begin
      op(0, 1, 0, 16'h0000);
      check("drain_sr", sr, (k < 8) ? (16'hA000 + 16'(7 - k)) : 16'h0000);
    end
    check("drain_empty", empty, 1);
    check("drain_ovf_sticky", overflow, 1);
    check("drain_udf", underflow, 0);
    op(0, 0, 1, 16'h0000);
    check("clr_ovf", overflow, 0);

    // Underflow, then push+pop on an empty stack
    op(0, 1, 0, 16'h0000);
    check("udf_flag", underflow, 1);
    check("udf_count", count, 0);
    op(1, 1, 0, 16'h00AA);
    check("pp_empty_count", count, 1);
    check("pp_empty_sr", sr, 16'h00AA);
    check("pp_empty_udf", underflow, 1);

    // Replace top
    op(1, 0, 0, 16'h0005);
    check("rep_pre_sr", sr, 16'h0005);
    op(1, 1, 0, 16'h0007);
    check("rep_count", count, 2);
    check("rep_sr", sr, 16'h0007);
    op(0, 1, 0, 16'h0000);
    check("rep_below_sr", sr, 16'h00AA);
    op(0, 0, 1, 16'h0000);
    for (int i = 0; i < 8; i++) op(1, 0, 0, 16'hB000 + 16'(i));
    op(1, 1, 0, 16'h0007);
    check("rep_full_ovf", overflow, 0);
    check("rep_full_count", count, 8);
    check("rep_full_sr", sr, 16'h0007);
    op(0, 1, 0, 16'h0000);
    check("rep_full_below", sr, 16'hB006);

    // clear beats push: rebuild count=5 with overflow set
    op(1, 0, 0, 16'hB007);
    op(1, 0, 0, 16'hCAFE);
    check("c5_ovf_set", overflow, 1);
    op(0, 1, 0, 16'h0000);
    op(0, 1, 0, 16'h0000);
    op(0, 1, 0, 16'h0000);
    check("c5_count", count, 5);
    op(1, 0, 1, 16'hDEAD);
    check("clrpush_count", count, 0);
    check("clrpush_ovf", overflow, 0);
    check("clrpush_sr", sr, 16'h0000);

    // Asynchronous reset mid-cycle
    for (int i = 0; i < 4; i++) op(1, 0, 0, 16'hC000 + 16'(i));
    check("ar_pre_count", count, 4);
    #2 reset = 1'b1;
    #1;
    check("ar_count", count, 0);
    check("ar_empty", empty, 1);
    check("ar_sr", sr, 16'h0000);
    @(posedge CLK); #2;
    reset = 1'b0;
    op(1, 0, 0, 16'h1234);
    check("ar_post_count", count, 1);
    check("ar_post_sr", sr, 16'h1234);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
